maxnet_iter_ctrl: RTL and testbench

- Parametrised iteration controller for the iterative winner-search datapath.
- Sequences the stages load → activation → multiply → accumulate → check, and loops until the datapath raises found.
- Extends the earlier single-cycle-per-stage controller with:
  - configurable multiply and add latencies;
  - an iteration limit with timeout reporting;
  - an abort input, busy status, an iteration counter, and sticky result flags.

---
 rtl/maxnet_iter_ctrl.sv | 163 ++++++++++++++++
 tb/tb_maxnet_iter_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_iter_ctrl.sv
// maxnet_iter_ctrl: iteration controller for the iterative winner-search datapath.
// Sequences LOAD -> ACT -> MULT -> ADD -> CHECK and loops back to ACT until the
// datapath reports found, the iteration limit is reached, or the run is aborted.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begin a run (honoured in IDLE and DONE only)
//   abort             drop a run in progress back to IDLE
//   found             datapath convergence flag (looked at in CHECK only)
//   mainRegWrite      load input vector into main registers
//   actWrite          write activation register
//   multWrite         write multiplier output register (last MULT cycle)
//   addWrite          write accumulator register (last ADD cycle)
//   sel               activation source: 0 = main regs, 1 = feedback
//   busy, done        run in progress / one-cycle completion pulse
//   timeout           sticky: last run hit the iteration limit
//   found_flag        sticky: last run converged
//   iter_count        completed non-converged passes
//
// All outputs are registers; the strobes, busy and done are loaded from the
// state being entered, so they read as a Moore decode of the current state.
module maxnet_iter_ctrl #(
    parameter int unsigned MULT_LAT = 1,
    parameter int unsigned ADD_LAT  = 1,
    parameter int unsigned MAX_ITER = 16,
    parameter int unsigned ITER_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              found,
    output logic              mainRegWrite,
    output logic              actWrite,
    output logic              multWrite,
    output logic              addWrite,
    output logic              sel,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              found_flag,
    output logic [ITER_W-1:0] iter_count
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0]  MULT_LAST = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0]  ADD_LAST  = CNT_W'(ADD_LAT - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACT,
        S_MULT,
        S_ADD,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] stage_cnt;

    // State, stage counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            stage_cnt    <= '0;
            mainRegWrite <= 1'b0;
            actWrite     <= 1'b0;
            multWrite    <= 1'b0;
            addWrite     <= 1'b0;
            sel          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            found_flag   <= 1'b0;
            iter_count   <= '0;
        end else begin
            mainRegWrite <= 1'b0;
            actWrite     <= 1'b0;
            multWrite    <= 1'b0;
            addWrite     <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b1;

            if (abort && (state != S_IDLE) && (state != S_DONE)) begin
                // Abort outranks found and the limit check; flags and count hold.
                state     <= S_IDLE;
                stage_cnt <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            state        <= S_LOAD;
                            iter_count   <= '0;
                            timeout      <= 1'b0;
                            found_flag   <= 1'b0;
                            sel          <= 1'b0;
                            mainRegWrite <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        state    <= S_ACT;
                        actWrite <= 1'b1;
                    end
                    S_ACT: begin
                        state     <= S_MULT;
                        stage_cnt <= '0;
                        multWrite <= (MULT_LAT == 1);
                    end
                    S_MULT: begin
                        if (stage_cnt == MULT_LAST) begin
                            state     <= S_ADD;
                            stage_cnt <= '0;
                            addWrite  <= (ADD_LAT == 1);
                        end else begin
                            stage_cnt <= stage_cnt + CNT_W'(1);
                            multWrite <= ((stage_cnt + CNT_W'(1)) == MULT_LAST);
                        end
                    end
                    S_ADD: begin
                        if (stage_cnt == ADD_LAST) begin
                            state     <= S_CHECK;
                            stage_cnt <= '0;
                        end else begin
                            stage_cnt <= stage_cnt + CNT_W'(1);
                            addWrite  <= ((stage_cnt + CNT_W'(1)) == ADD_LAST);
                        end
                    end
                    S_CHECK: begin
                        if (found) begin
                            // Convergence wins over a coincident limit.
                            state      <= S_DONE;
                            found_flag <= 1'b1;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                        end else if (iter_count == ITER_LAST) begin
                            state      <= S_DONE;
                            iter_count <= iter_count + ITER_W'(1);
                            timeout    <= 1'b1;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            state      <= S_ACT;
                            iter_count <= iter_count + ITER_W'(1);
                            sel        <= 1'b1;
                            actWrite   <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// Bench for maxnet_iter_ctrl: two instances (1/1/16 and 3/2/4 latencies/limit)
// checked every cycle against a run-timeline model, plus literal spot checks.
module tb_maxnet_iter_ctrl;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_v, abort_v, found_v;
    logic [1:0] mrw, aw, mw, adw, sel_v, busy_v, done_v, to_v, ff_v;
    logic [7:0] it0;
    logic [3:0] it1;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    maxnet_iter_ctrl #(.MULT_LAT(1), .ADD_LAT(1), .MAX_ITER(16), .ITER_W(8)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .found(found_v[0]),
        .mainRegWrite(mrw[0]), .actWrite(aw[0]), .multWrite(mw[0]), .addWrite(adw[0]),
        .sel(sel_v[0]), .busy(busy_v[0]), .done(done_v[0]), .timeout(to_v[0]),
        .found_flag(ff_v[0]), .iter_count(it0)
    );

    maxnet_iter_ctrl #(.MULT_LAT(3), .ADD_LAT(2), .MAX_ITER(4), .ITER_W(4)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .found(found_v[1]),
        .mainRegWrite(mrw[1]), .actWrite(aw[1]), .multWrite(mw[1]), .addWrite(adw[1]),
        .sel(sel_v[1]), .busy(busy_v[1]), .done(done_v[1]), .timeout(to_v[1]),
        .found_flag(ff_v[1]), .iter_count(it1)
    );

    function automatic int p_ml(input int i); return (i == 0) ? 1 : 3; endfunction
    function automatic int p_al(input int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int p_mx(input int i); return (i == 0) ? 16 : 4; endfunction

    // Model: a run is a timeline t counted from LOAD (t=0); pass k starts at
    // t = 1 + k*P with P = 2 + MULT_LAT + ADD_LAT, its CHECK at the pass end.
    bit m_act [N];
    int m_t   [N];
    int m_iter[N];
    bit m_to  [N];
    bit m_ff  [N];
    bit m_sel [N];
    bit m_done[N];

    task automatic model_step(input int i);
        int p;
        p = 2 + p_ml(i) + p_al(i);
        if (rst) begin
            m_act[i] = 0; m_t[i] = 0; m_iter[i] = 0;
            m_to[i] = 0; m_ff[i] = 0; m_sel[i] = 0; m_done[i] = 0;
        end else if (!m_act[i]) begin
            m_done[i] = 0;
            if (start_v[i]) begin
                m_act[i] = 1; m_t[i] = 0; m_iter[i] = 0;
                m_to[i] = 0; m_ff[i] = 0; m_sel[i] = 0;
            end
        end else if (abort_v[i]) begin
            m_act[i] = 0;
        end else if (m_t[i] >= 1 && (m_t[i] - 1) % p == p - 1) begin
            if (found_v[i]) begin
                m_ff[i] = 1; m_act[i] = 0; m_done[i] = 1;
            end else begin
                m_iter[i]++;
                if (m_iter[i] == p_mx(i)) begin
                    m_to[i] = 1; m_act[i] = 0; m_done[i] = 1;
                end else begin
                    m_sel[i] = 1; m_t[i]++;
                end
            end
        end else begin
            m_t[i]++;
        end
    endtask

    function automatic logic [16:0] exp_vec(input int i);
        int p, o;
        logic mr, a, m, ad;
        mr = 0; a = 0; m = 0; ad = 0;
        p = 2 + p_ml(i) + p_al(i);
        if (m_act[i]) begin
            if (m_t[i] == 0) mr = 1;
            else begin
                o  = (m_t[i] - 1) % p;
                a  = (o == 0);
                m  = (o == p_ml(i));
                ad = (o == p_ml(i) + p_al(i));
            end
        end
        return {mr, a, m, ad, m_sel[i], m_act[i], m_done[i], m_to[i], m_ff[i], 8'(m_iter[i])};
    endfunction

    function automatic logic [16:0] act_vec(input int i);
        logic [7:0] it;
        it = (i == 0) ? it0 : {4'b0, it1};
        return {mrw[i], aw[i], mw[i], adw[i], sel_v[i], busy_v[i], done_v[i], to_v[i], ff_v[i], it};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) model_step(i);
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL model_u%0d @%0t: got %05h expected %05h", i, $time, act_vec(i), exp_vec(i));
                end
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start_v = '0; abort_v = '0; found_v = '0;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        lit("reset_u0", act_vec(0), 17'h0);
        lit("reset_u1", act_vec(1), 17'h0);
        rst = 1'b0;
        tick();

        // 1: single pass, found at first CHECK (u0)
        found_v[0] = 1'b1; start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        @(negedge clk); lit("t1_load", mrw[0], 1);
        tick(); @(negedge clk); lit("t1_act", aw[0], 1);
        tick(); @(negedge clk); lit("t1_mult", mw[0], 1);
        tick(); @(negedge clk); lit("t1_add", adw[0], 1);
        tick(); @(negedge clk); lit("t1_check_busy", {busy_v[0], done_v[0]}, 2'b10);
        tick(); @(negedge clk);
        lit("t1_done", done_v[0], 1);
        lit("t1_flags", {ff_v[0], to_v[0], sel_v[0]}, 3'b100);
        lit("t1_iter", it0, 0);
        found_v[0] = 1'b0;
        tick(); tick();

        // 2: MULT 3 / ADD 2, found at the third CHECK (u1): CHECKs at 8, 15, 22
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            found_v[1] = (c == 22);
            @(negedge clk);
            lit("t2_done", done_v[1], (c == 23));
            if (c == 2)  lit("t2_sel_first", sel_v[1], 0);
            if (c == 9)  lit("t2_sel_second", {sel_v[1], aw[1]}, 2'b11);
            if (c == 23) lit("t2_result", {ff_v[1], to_v[1], it1}, {2'b10, 4'd2});
            tick();
        end
        found_v[1] = 1'b0;

        // 3: limit reached with found held low (u1): CHECKs at 8, 15, 22, 29
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            lit("t3_done", done_v[1], (c == 30));
            if (c == 30) lit("t3_result", {ff_v[1], to_v[1], it1}, {2'b01, 4'd4});
            tick();
        end

        // 4: found on the final allowed CHECK beats the limit (u1)
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            found_v[1] = (c == 29);
            @(negedge clk);
            if (c == 30) lit("t4_result", {done_v[1], ff_v[1], to_v[1], it1}, {3'b110, 4'd3});
            tick();
        end
        found_v[1] = 1'b0;

        // 5: abort during the second MULT (cycle 7 on u0), then restart
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            abort_v[0] = (c == 7);
            @(negedge clk);
            lit("t5_no_done", done_v[0], 0);
            if (c == 8) lit("t5_aborted", {busy_v[0], ff_v[0], to_v[0], it0}, {3'b000, 8'd1});
            tick();
        end
        abort_v[0] = 1'b0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        @(negedge clk); lit("t5_restart", {mrw[0], it0}, {1'b1, 8'd0});
        repeat (10) tick();
        abort_v[0] = 1'b1;
        tick();
        abort_v[0] = 1'b0;
        tick();

        // 6: start held through DONE restarts directly; rst during ADD
        found_v[0] = 1'b1; start_v[0] = 1'b1;
        tick();
        for (int c = 1; c <= 12; c++) begin
            if (c == 7) found_v[0] = 1'b0;
            rst = (c == 10);
            start_v[0] = (c < 10);
            @(negedge clk);
            if (c == 6)  lit("t6_done", {done_v[0], ff_v[0]}, 2'b11);
            if (c == 7)  lit("t6_reload", {mrw[0], done_v[0], ff_v[0], to_v[0]}, 4'b1000);
            if (c == 10) lit("t6_in_add", adw[0], 1);
            if (c == 11) lit("t6_reset", act_vec(0), 17'h0);
            tick();
        end
        rst = 1'b0; start_v = '0; found_v = '0;
        tick();

        // Random stimulus on both instances
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                start_v[i] = ($urandom_range(7) == 0);
                abort_v[i] = ($urandom_range(39) == 0);
                found_v[i] = ($urandom_range(3) == 0);
            end
            rst = ($urandom_range(299) == 0);
            tick();
        end
        rst = 1'b0; start_v = '0; abort_v = '0; found_v = '0;
        tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
